sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shares one external clocked SR flip-flop (a status flag) among N_REQ requesters.
- Each requester asks to set or clear the flag with a req/gnt handshake.
- The block serialises requests in round-robin order and drives the flip-flop's s/r inputs.
- It guarantees s and r are never both 1, reads q back to confirm each operation, and retries on mismatch.

Parameters:
N_REQ, 4, number of requesters (2..16)
PULSE_CYC, 2, cycles s or r is held high per attempt (>=1)
MAX_RETRY, 3, extra attempts after the first before declaring failure (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request, held high until its gnt
op  input  N_REQ  per-requester operation: 1 = set flag, 0 = clear flag; valid while req high
gnt  output  N_REQ  one-hot, one-cycle completion pulse to the owning requester
fail  output  1  one-cycle pulse coincident with gnt when all attempts failed
err  output  1  sticky failure flag, cleared only by rst
busy  output  1  high from selection through the DONE cycle
owner  output  clog2(N_REQ)  index of the current or last served requester
sr_s  output  1  drives flip-flop s input
sr_r  output  1  drives flip-flop r input
sr_q  input  1  flip-flop q readback

Behaviour:
- Reset values, applied on any edge with rst=1 regardless of state:
  - state = IDLE; sr_s = sr_r = 0; gnt = 0; fail = 0; err = 0; busy = 0; owner = 0.
  - Round-robin pointer ptr = 0; retry count = 0.
  - Reset mid-transaction drops s/r at that edge; no gnt is issued for the aborted request.
- All outputs are registered.
- Invariant: sr_s & sr_r is never 1. The bench asserts this every cycle.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE, on edge k with any req bit high:
  - Select the first asserted index scanning ptr, ptr+1, ... modulo N_REQ.
  - Latch idx into owner and latch op[idx]; retry = 0.
  - Set sr_s = op, sr_r = ~op, busy = 1, cnt = PULSE_CYC-1; go to DRIVE.
  - With no req high, stay in IDLE with all outputs low.
- DRIVE:
  - cnt>0: decrement cnt.
  - cnt==0: sr_s = sr_r = 0; go to CHECK.
  - Net effect: s or r is high for exactly PULSE_CYC cycles.
- CHECK, one cycle; sr_q is sampled at its edge:
  - sr_q == op: gnt[owner] = 1; go to DONE.
  - Mismatch and retry < MAX_RETRY: retry++; reassert s/r as in IDLE; go to DRIVE.
  - Mismatch and retry == MAX_RETRY: gnt[owner] = 1, fail = 1, err = 1; go to DONE.
- DONE, one cycle:
  - gnt (and fail) are high during this cycle.
  - At its edge: gnt = fail = 0, busy = 0, ptr = owner+1 mod N_REQ; go to IDLE.
  - The requester drops req on the edge ending DONE, so IDLE never re-selects a finished request.
- Latency:
  - Select at edge k; gnt high in the cycle after edge k+PULSE_CYC+1.
  - Next selection no earlier than edge k+PULSE_CYC+3.
  - Each retry adds PULSE_CYC+1 cycles.
- Request and op handling:
  - op and req changes after selection are ignored.
  - A requester dropping req mid-transaction still receives its gnt pulse.
- Simultaneous requests: exactly one is served; the others wait. Served index becomes lowest priority.
- Redundant ops are still driven and checked normally (e.g. set when q is already 1).
- Round-robin pointer wraps N_REQ-1 to 0.
- Throughput: one transaction per PULSE_CYC+3 cycles with no retries.

Test Plan:
- Reset hold 3 cycles, then release with req=0 -> all outputs 0, state IDLE, owner=0.
- req=4'b0010, op[1]=1, flip-flop model healthy -> sr_s=1 for 2 cycles, sr_r=0 throughout; gnt=4'b0010 for one cycle, 4 cycles after selection edge; sr_q=1, fail=0.
- req=4'b1111, ops alternating 1,0,1,0, held until gnt -> grants in order 0,1,2,3, then 0 again if re-requested; never two gnt bits high; sr_s&sr_r never 1.
- After serving index 2, req=4'b0101 -> index 0 served before index 2 (ptr=3 wraps to 0).
- Model with q stuck at 0, set request from index 3 -> 4 drive attempts (1+MAX_RETRY); gnt[3]=1 with fail=1; err stays 1 through later successful transactions until rst.
- rst asserted in the second DRIVE cycle -> next cycle sr_s=sr_r=0, busy=0, no gnt; a held req is re-selected from ptr=0 after rst release.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares one external clocked SR flip-flop among N_REQ requesters.
// Each set/clear request is pulsed, read back through q, and retried on mismatch.
module sr_flag_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         op,
    output logic [N_REQ-1:0]         gnt,
    output logic                     fail,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     sr_s,
    output logic                     sr_r,
    input  logic                     sr_q
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(PULSE_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CW-1:0] CNT_INIT  = CW'(PULSE_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);

    logic [1:0]       state_r;
    logic [OW-1:0]    ptr_r;
    logic [OW-1:0]    owner_r;
    logic             op_r;
    logic [3:0]       retry_r;
    logic [CW-1:0]    cnt_r;
    logic [N_REQ-1:0] gnt_r;
    logic             fail_r;
    logic             err_r;
    logic             busy_r;
    logic             sr_s_r;
    logic             sr_r_r;

    logic             sel_found_s;
    logic [OW-1:0]    sel_idx_s;
    logic             sel_op_s;
    logic [OW-1:0]    ptr_next_s;
    int               scan_s;

    // One-hot grant vector for a given requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        onehot = N_REQ'(1) << idx;
    endfunction

    // Round-robin scan: walk offsets from high to low so the nearest asserted index to ptr wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        scan_s      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_s = int'(ptr_r) + i;
            if (scan_s >= N_REQ) begin
                scan_s = scan_s - N_REQ;
            end else begin
                scan_s = scan_s;
            end
            if (req[scan_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = scan_s[OW-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Operation of the selected requester and the pointer value after serving the owner.
    always_comb begin
        sel_op_s = op[sel_idx_s];
        if (owner_r == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = owner_r + OW'(1);
        end
    end

    // Main FSM: select, pulse s/r, verify q, grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            op_r    <= 1'b0;
            retry_r <= 4'd0;
            cnt_r   <= '0;
            gnt_r   <= '0;
            fail_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            sr_s_r  <= 1'b0;
            sr_r_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_found_s) begin
                        owner_r <= sel_idx_s;
                        op_r    <= sel_op_s;
                        retry_r <= 4'd0;
                        sr_s_r  <= sel_op_s;
                        sr_r_r  <= ~sel_op_s;
                        busy_r  <= 1'b1;
                        cnt_r   <= CNT_INIT;
                        state_r <= ST_DRIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        sr_s_r  <= 1'b0;
                        sr_r_r  <= 1'b0;
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sr_q == op_r) begin
                        gnt_r   <= onehot(owner_r);
                        state_r <= ST_DONE;
                    end else if (retry_r < RETRY_MAX) begin
                        retry_r <= retry_r + 4'd1;
                        sr_s_r  <= op_r;
                        sr_r_r  <= ~op_r;
                        cnt_r   <= CNT_INIT;
                        state_r <= ST_DRIVE;
                    end else begin
                        gnt_r   <= onehot(owner_r);
                        fail_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt_r   <= '0;
                    fail_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ptr_r   <= ptr_next_s;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                    fail_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    sr_s_r  <= 1'b0;
                    sr_r_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign fail  = fail_r;
    assign err   = err_r;
    assign busy  = busy_r;
    assign owner = owner_r;
    assign sr_s  = sr_s_r;
    assign sr_r  = sr_r_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter with a behavioural SR flip-flop that can be forced stuck at 0.
module tb_sr_flag_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] op;
    logic [3:0] gnt;
    logic       fail;
    logic       err;
    logic       busy;
    logic [1:0] owner;
    logic       sr_s;
    logic       sr_r;
    logic       sr_q;
    logic       stuck;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic       f;
    } exp_t;
    exp_t exp_q[$];

    sr_flag_arbiter #(.N_REQ(4), .PULSE_CYC(2), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .gnt(gnt), .fail(fail),
        .err(err), .busy(busy), .owner(owner), .sr_s(sr_s), .sr_r(sr_r), .sr_q(sr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External flip-flop model; stuck forces q low to exercise retries.
    initial sr_q = 1'b0;
    always @(posedge clk) begin
        if (stuck) sr_q <= 1'b0;
        else if (sr_s) sr_q <= 1'b1;
        else if (sr_r) sr_q <= 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: invariant checks every cycle, scoreboard pop on every grant.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_and_r", {31'd0, sr_s & sr_r}, 32'd0);
            chk("gnt_onehot", {31'd0, ($countones(gnt) > 1)}, 32'd0);
            if (gnt != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("gnt", {28'd0, gnt}, {28'd0, e.g});
                    chk("fail", {31'd0, fail}, {31'd0, e.f});
                end
            end
        end
    end

    // Let requesters drop on grant until everything is served; counts s pulses seen.
    task automatic run_until_idle(input int budget, output int s_pulses);
        logic prev;
        int   n;
        prev     = sr_s;
        s_pulses = 0;
        n        = 0;
        while (n < budget && !(req == 4'd0 && !busy)) begin
            @(negedge clk);
            n++;
            if (sr_s && !prev) s_pulses++;
            prev = sr_s;
            if (gnt != 4'd0) req = req & ~gnt;
        end
        chk("idle_timeout", {31'd0, (n < budget)}, 32'd1);
    endtask

    int pulses;

    initial begin
        rst   = 1'b1;
        req   = 4'd0;
        op    = 4'd0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_s", {31'd0, sr_s}, 32'd0);
        chk("rst_r", {31'd0, sr_r}, 32'd0);

        // All four request, alternating set/clear: served 0,1,2,3.
        req = 4'b1111;
        op  = 4'b0101;
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0010, 1'b0});
        exp_q.push_back('{4'b0100, 1'b0});
        exp_q.push_back('{4'b1000, 1'b0});
        run_until_idle(200, pulses);
        chk("all4_s_pulses", pulses, 32'd2);
        chk("all4_owner", {30'd0, owner}, 32'd3);

        // Single set from index 1, cycle-accurate timing.
        req = 4'b0010;
        op  = 4'b0010;
        exp_q.push_back('{4'b0010, 1'b0});
        @(negedge clk);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_owner", {30'd0, owner}, 32'd1);
        chk("t2_s_c1", {31'd0, sr_s}, 32'd1);
        chk("t2_r_c1", {31'd0, sr_r}, 32'd0);
        @(negedge clk);
        chk("t2_s_c2", {31'd0, sr_s}, 32'd1);
        chk("t2_r_c2", {31'd0, sr_r}, 32'd0);
        @(negedge clk);
        chk("t2_s_c3", {31'd0, sr_s}, 32'd0);
        chk("t2_gnt_c3", {28'd0, gnt}, 32'd0);
        @(negedge clk);
        chk("t2_gnt_c4", {28'd0, gnt}, 32'h2);
        chk("t2_fail_c4", {31'd0, fail}, 32'd0);
        chk("t2_q", {31'd0, sr_q}, 32'd1);
        req = 4'd0;
        @(negedge clk);
        chk("t2_gnt_c5", {28'd0, gnt}, 32'd0);
        chk("t2_busy_c5", {31'd0, busy}, 32'd0);

        // Serve 2 (clear), then 0101: pointer 3 wraps so 0 goes first.
        req = 4'b0100;
        op  = 4'b0000;
        exp_q.push_back('{4'b0100, 1'b0});
        run_until_idle(100, pulses);
        chk("t4_q_clear", {31'd0, sr_q}, 32'd0);
        req = 4'b0101;
        op  = 4'b0001;
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0100, 1'b0});
        run_until_idle(200, pulses);
        chk("t4_owner", {30'd0, owner}, 32'd2);

        // q stuck at 0: index 3 set fails after 1+3 attempts.
        stuck = 1'b1;
        req   = 4'b1000;
        op    = 4'b1000;
        exp_q.push_back('{4'b1000, 1'b1});
        run_until_idle(200, pulses);
        chk("t5_attempts", pulses, 32'd4);
        chk("t5_err", {31'd0, err}, 32'd1);
        stuck = 1'b0;
        req   = 4'b0001;
        op    = 4'b0001;
        exp_q.push_back('{4'b0001, 1'b0});
        run_until_idle(100, pulses);
        chk("t5_err_sticky", {31'd0, err}, 32'd1);
        chk("t5_q_ok", {31'd0, sr_q}, 32'd1);

        // Reset in the second DRIVE cycle of index 2 (ptr is 1), req held across reset.
        req = 4'b0101;
        op  = 4'b0101;
        @(negedge clk);
        chk("t6_owner_sel", {30'd0, owner}, 32'd2);
        @(negedge clk);
        chk("t6_s_drive", {31'd0, sr_s}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_s", {31'd0, sr_s}, 32'd0);
        chk("t6_r", {31'd0, sr_r}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_gnt", {28'd0, gnt}, 32'd0);
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_owner", {30'd0, owner}, 32'd0);
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0100, 1'b0});
        run_until_idle(200, pulses);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
